// File: rtl/full_adder.sv
// full_adder
//   Single-bit full adder: the leaf cell of the ripple-carry adder chains.
//   A combinational path feeds carry chains directly. A registered path
//   delays {valid, cout, sum} by PIPE_STAGES enabled clock edges so the same
//   cell can be used in registered datapaths.
//
// Parameters
//   PIPE_STAGES  register stages on the registered path, 1..8 (default 1)
//
// Ports
//   clk        in   rising-edge clock for the registered path
//   rst_n      in   asynchronous active-low reset, clears every stage
//   a, b, cin  in   operand bits and carry-in
//   sum        out  combinational a ^ b ^ cin
//   cout       out  combinational (a & b) | (cin & (a ^ b))
//   gen        out  combinational carry-generate a & b
//   prop       out  combinational carry-propagate a ^ b
//   en         in   pipeline advance enable; 0 freezes every stage
//   valid_in   in   marks a, b, cin as a valid operation
//   sum_q      out  registered sum, PIPE_STAGES enabled edges late
//   cout_q     out  registered carry-out, aligned with sum_q
//   valid_out  out  valid flag aligned with sum_q / cout_q
module full_adder #(
    parameter int unsigned PIPE_STAGES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout,
    output logic gen,
    output logic prop,
    input  logic en,
    input  logic valid_in,
    output logic sum_q,
    output logic cout_q,
    output logic valid_out
);

    generate
        if (PIPE_STAGES < 1 || PIPE_STAGES > 8) begin : g_bad_stages
            $error("full_adder: PIPE_STAGES must be in 1..8");
        end
    endgenerate

    // Combinational leaf: no dependence on clk, reset or qualifiers.
    assign prop = a ^ b;
    assign gen  = a & b;
    assign sum  = prop ^ cin;
    assign cout = gen | (cin & prop);

    // Stage 0 is bit 0; the last stage drives the registered outputs.
    logic [PIPE_STAGES-1:0] v_q;
    logic [PIPE_STAGES-1:0] s_q;
    logic [PIPE_STAGES-1:0] c_q;

    // Single-stage case is split out so the shift slice never goes negative.
    generate
        if (PIPE_STAGES == 1) begin : g_one_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= '0;
                    s_q <= '0;
                    c_q <= '0;
                end else if (en) begin
                    v_q <= valid_in;
                    s_q <= sum;
                    c_q <= cout;
                end
            end
        end else begin : g_multi_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= '0;
                    s_q <= '0;
                    c_q <= '0;
                end else if (en) begin
                    v_q <= {v_q[PIPE_STAGES-2:0], valid_in};
                    s_q <= {s_q[PIPE_STAGES-2:0], sum};
                    c_q <= {c_q[PIPE_STAGES-2:0], cout};
                end
            end
        end
    endgenerate

    assign valid_out = v_q[PIPE_STAGES-1];
    assign sum_q     = s_q[PIPE_STAGES-1];
    assign cout_q    = c_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

    localparam int unsigned S = 3;

    // Hand-computed truth tables indexed by {a,b,cin}.
    localparam logic [1:0] FA_TBL [8] = '{2'b00, 2'b01, 2'b01, 2'b10,
                                          2'b01, 2'b10, 2'b10, 2'b11};
    localparam logic [7:0] GEN_TBL  = 8'b1100_0000;
    localparam logic [7:0] PROP_TBL = 8'b0011_1100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a = 1'b0, b = 1'b0, cin = 1'b0;
    logic en = 1'b0, valid_in = 1'b0;
    logic sum, cout, gen, prop, sum_q, cout_q, valid_out;

    always #5 clk = ~clk;

    full_adder #(.PIPE_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
        .sum(sum), .cout(cout), .gen(gen), .prop(prop),
        .en(en), .valid_in(valid_in),
        .sum_q(sum_q), .cout_q(cout_q), .valid_out(valid_out)
    );

    // 4-bit ripple chain: 1011 + 1101 + 0 = 1_1000
    logic [3:0] ra = 4'b1011;
    logic [3:0] rb = 4'b1101;
    logic [4:0] rc;
    logic [3:0] rs, rg, rp, rsq, rcq, rvo;
    assign rc[0] = 1'b0;

    genvar j;
    generate
        for (j = 0; j < 4; j++) begin : g_chain
            full_adder u_cell (
                .clk(clk), .rst_n(rst_n), .a(ra[j]), .b(rb[j]), .cin(rc[j]),
                .sum(rs[j]), .cout(rc[j+1]), .gen(rg[j]), .prop(rp[j]),
                .en(1'b0), .valid_in(1'b0),
                .sum_q(rsq[j]), .cout_q(rcq[j]), .valid_out(rvo[j])
            );
        end
    endgenerate

    typedef struct {
        logic [1:0]  cs;
        int unsigned due;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int unsigned en_edges = 0;
    logic en_last = 1'b0;
    logic [2:0] prev_out = '0;
    logic have_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Count only enabled edges out of reset; latency is measured in these.
    always @(posedge clk) begin
        if (rst_n) begin
            en_last = en;
            if (en) en_edges++;
        end else begin
            en_last = 1'b0;
        end
    end

    // Monitor: pops one expectation per enabled edge that presents valid_out.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            have_prev = 1'b0;
        end else begin
            if (!en_last && have_prev)
                chk("stall_hold", {29'd0, valid_out, cout_q, sum_q}, {29'd0, prev_out});
            if (valid_out && en_last) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("pipe_data", {30'd0, cout_q, sum_q}, {30'd0, e.cs});
                    chk("pipe_latency", en_edges, e.due);
                end
            end
            prev_out = {valid_out, cout_q, sum_q};
            have_prev = 1'b1;
        end
    end

    task automatic drive(input logic [2:0] abc, input logic v, input logic e);
        @(negedge clk);
        {a, b, cin} = abc;
        valid_in = v;
        en = e;
        if (v && e && rst_n)
            sb.push_back('{FA_TBL[abc], en_edges + S});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] idx;
        #1;
        chk("reset_valid_out", {31'd0, valid_out}, 32'd0);
        chk("reset_sum_q", {31'd0, sum_q}, 32'd0);
        chk("reset_cout_q", {31'd0, cout_q}, 32'd0);

        // Exhaustive combinational check.
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            {a, b, cin} = idx;
            #1;
            chk("comb_cout_sum", {30'd0, cout, sum}, {30'd0, FA_TBL[idx]});
            chk("comb_gen", {31'd0, gen}, {31'd0, GEN_TBL[idx]});
            chk("comb_prop", {31'd0, prop}, {31'd0, PROP_TBL[idx]});
        end

        chk("ripple_sum", {28'd0, rs}, 32'h8);
        chk("ripple_cout", {31'd0, rc[4]}, 32'd1);

        @(negedge clk);
        rst_n = 1'b1;

        // Stream all combinations with a 2-cycle stall in the middle;
        // the stalled inputs carry valid_in=1 but must not be captured.
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                drive(3'b111, 1'b1, 1'b0);
                drive(3'b000, 1'b1, 1'b0);
            end
            drive(3'(i), 1'b1, 1'b1);
        end
        repeat (5) drive(3'b000, 1'b0, 1'b1);

        // Bubbles: valid 1,0,1 with a=b=cin=1.
        drive(3'b111, 1'b1, 1'b1);
        drive(3'b111, 1'b0, 1'b1);
        drive(3'b111, 1'b1, 1'b1);
        repeat (5) drive(3'b000, 1'b0, 1'b1);

        // Reset with two operations in flight, asserted between edges.
        drive(3'b011, 1'b1, 1'b1);
        drive(3'b101, 1'b1, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_valid_out", {31'd0, valid_out}, 32'd0);
        chk("midreset_sum_q", {31'd0, sum_q}, 32'd0);
        chk("midreset_cout_q", {31'd0, cout_q}, 32'd0);
        sb.delete();
        valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b110, 1'b1, 1'b1);
        drive(3'b001, 1'b1, 1'b1);
        repeat (4) drive(3'b000, 1'b0, 1'b1);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        chk("drain_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/full_adder.md
# full_adder

Single-bit full adder used as the leaf cell of the ripple-carry adders (fixed 4-bit and N-bit generate chains). It computes sum and carry-out of two operand bits and a carry-in. The combinational path feeds carry chains directly. A clocked path with a parameterized pipeline delay and valid/enable qualifiers lets the same cell be used in registered datapaths.

## Interface
- PIPE_STAGES, default 1: number of register stages on the registered path. Legal range 1..8. Values outside the range are a compile-time error.
- clk  input  1  rising-edge clock for the registered path.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  1  operand bit A.
- b  input  1  operand bit B.
- cin  input  1  carry-in.
- sum  output  1  combinational sum, a ^ b ^ cin.
- cout  output  1  combinational carry-out, (a & b) | (cin & (a ^ b)).
- gen  output  1  combinational carry-generate, a & b.
- prop  output  1  combinational carry-propagate, a ^ b.
- en  input  1  pipeline advance enable; 0 freezes every stage.
- valid_in  input  1  marks a, b, cin as a valid operation for the registered path.
- sum_q  output  1  registered sum, delayed PIPE_STAGES cycles.
- cout_q  output  1  registered carry-out, delayed PIPE_STAGES cycles.
- valid_out  output  1  valid flag aligned with sum_q and cout_q.

## Operation
- Combinational outputs sum, cout, gen and prop depend only on a, b and cin.
  - They are independent of clk, rst_n, en and valid_in.
  - They have no X-propagation masking and no latches.
- Truth table for {a,b,cin} to {cout,sum}:
  - 000 → 00
  - 001, 010, 100 → 01
  - 011, 101, 110 → 10
  - 111 → 11
- Arithmetic: {cout,sum} = a + b + cin, a 2-bit unsigned result. No overflow case exists.
- Registered path: stage 0 captures {valid_in, cout, sum} from the combinational logic. Each later stage copies the stage before it.
  - The last stage drives valid_out, cout_q and sum_q.
- Data is captured regardless of valid_in. When valid_in=0, valid_out=0 for that slot and the sum_q/cout_q value is don't-care. The bench must check sum_q/cout_q only when valid_out=1.
- en=0: all stages hold their contents, including valid bits. No data is lost or duplicated.
- en=1: all stages advance together.

## Timing
- Combinational path: zero cycles of latency.
- Registered path: an operation presented with valid_in=1 and en=1 at rising edge k appears on sum_q, cout_q and valid_out=1 after edge k+PIPE_STAGES-1 completes. This counts only edges where en=1.
- Reset values: while rst_n=0, all stage registers are 0, so valid_out=0, sum_q=0 and cout_q=0.
  - Reset takes effect immediately and does not wait for clk.
- Reset deassertion: the first capture happens at the first rising edge after rst_n goes to 1.
- Reset mid-operation: in-flight operations are discarded and are never reported.
- en and valid_in are sampled only on rising edges. A simultaneous en=0 with valid_in=1 means the input is not captured.

## Test plan
- Exhaustive combinational check: apply all 8 {a,b,cin} combinations with 1 ns settle each.
  - Required {cout,sum} per the truth table, e.g. 111 → 11 and 101 → 10.
  - Required gen/prop, e.g. a=1, b=1 → gen=1, prop=0.
- Ripple chain: instantiate 4 cells chained through cout/cin and drive a=1011, b=1101, cin=0.
  - Required: sum=1000, cout=1.
- Pipeline latency with PIPE_STAGES=3 and en=1: stream all 8 combinations on consecutive edges with valid_in=1.
  - Required: valid_out=1 and matching {cout_q,sum_q} exactly 3 edges after each input.
- Stall: drop en=0 for 2 cycles mid-stream.
  - Required: outputs and valid_out hold.
  - Required: results resume in order with no loss or duplicates, and total latency grows by 2.
- Bubbles: set valid_in=1,0,1 with a=b=cin=1.
  - Required: valid_out pattern 1,0,1, with {cout_q,sum_q}=11 on the valid slots.
- Reset mid-operation: assert rst_n=0 between clock edges with 2 valid operations in flight.
  - Required: valid_out=0, sum_q=0 and cout_q=0 immediately.
  - Required: no stale valid output after release, and the first new result appears PIPE_STAGES edges after its capture.
